// File: rtl/core_bus_arbiter_pkg.sv
// Shared encodings for the core bus arbiter: FSM states, port owners and the
// write-mask to byte-strobe helper.
package core_bus_arbiter_pkg;

  localparam int REG_BUS = 64;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_WAIT = 2'd2;
  localparam logic [1:0] ARB_DONE = 2'd3;

  localparam logic ARB_OWN_INST = 1'b0;
  localparam logic ARB_OWN_DATA = 1'b1;

  // The core replicates each byte-enable across its 8 mask bits; bit 0 of each byte is enough.
  function automatic logic [7:0] mask_to_strb(input logic [REG_BUS-1:0] mask);
    logic [7:0] strb;
    strb = '0;
    for (int i = 0; i < 8; i++) begin
      strb[i] = mask[8*i];
    end
    return strb;
  endfunction

endpackage

// File: rtl/core_bus_arbiter_watchdog.sv
// Wait-state watchdog: counts enabled cycles after a clear and flags expiry on
// the cycle in which the count reaches CYCLES.
module bus_watchdog #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != W'(CYCLES))) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = i_enable && (r_count == W'(CYCLES - 1));

endmodule

// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch and load/store ports onto one single-outstanding
// valid/ready memory bus, alternating owners under contention.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_ena,
  input  logic [63:0]  inst_addr,
  output logic [63:0]  inst_rdata,
  output logic         inst_ready,
  input  logic         mem_rena,
  input  logic [63:0]  mem_raddr,
  input  logic         mem_wena,
  input  logic [63:0]  mem_waddr,
  input  logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_wmask,
  output logic [63:0]  mem_rdata,
  output logic         mem_ready,
  output logic         bus_req_valid,
  input  logic         bus_req_ready,
  output logic [63:0]  bus_req_addr,
  output logic         bus_req_wen,
  output logic [63:0]  bus_req_wdata,
  output logic [7:0]   bus_req_wstrb,
  input  logic         bus_resp_valid,
  input  logic [63:0]  bus_resp_rdata,
  output logic         bus_err
);

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_last_owner;
  logic        r_req_valid;
  logic [63:0] r_req_addr;
  logic        r_req_wen;
  logic [63:0] r_req_wdata;
  logic [7:0]  r_req_wstrb;
  logic [63:0] r_inst_rdata;
  logic [63:0] r_mem_rdata;
  logic        r_inst_ready;
  logic        r_mem_ready;
  logic        r_bus_err;

  logic [1:0]  w_state_next;
  logic        w_data_req;
  logic        w_grant_data;
  logic        w_start;
  logic        w_accept;
  logic        w_wd_enable;
  logic        w_expired;
  logic [63:0] w_sel_addr;
  logic        w_unused;

  assign w_data_req   = mem_rena | mem_wena;
  // Data normally wins, but a fetch waiting behind a completed data access goes next.
  assign w_grant_data = w_data_req && !((r_last_owner == ARB_OWN_DATA) && inst_ena);
  assign w_start      = (r_state == ARB_IDLE) && (w_data_req || inst_ena);
  assign w_accept     = (r_state == ARB_REQ) && bus_req_ready;
  assign w_wd_enable  = (r_state == ARB_WAIT) && !bus_resp_valid;
  assign w_sel_addr   = w_grant_data ? (mem_wena ? mem_waddr : mem_raddr) : inst_addr;

  assign w_unused = &{1'b0, inst_addr[2:0], mem_raddr[2:0], mem_waddr[2:0], mem_wmask};

  bus_watchdog #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_enable  (w_wd_enable),
    .o_expired (w_expired)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: if (w_start)                      w_state_next = ARB_REQ;
      ARB_REQ:  if (bus_req_ready)                w_state_next = ARB_WAIT;
      ARB_WAIT: if (bus_resp_valid || w_expired)  w_state_next = ARB_DONE;
      default:                                    w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= ARB_OWN_INST;
      r_last_owner <= ARB_OWN_INST;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_req_wen    <= 1'b0;
      r_req_wdata  <= '0;
      r_req_wstrb  <= '0;
      r_inst_rdata <= '0;
      r_mem_rdata  <= '0;
      r_inst_ready <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_req_valid  <= (w_state_next == ARB_REQ);
      r_inst_ready <= (w_state_next == ARB_DONE) && (r_owner == ARB_OWN_INST);
      r_mem_ready  <= (w_state_next == ARB_DONE) && (r_owner == ARB_OWN_DATA);

      if (w_start) begin
        r_owner     <= w_grant_data ? ARB_OWN_DATA : ARB_OWN_INST;
        r_req_addr  <= {w_sel_addr[63:3], 3'b000};
        r_req_wen   <= w_grant_data && mem_wena;
        r_req_wdata <= (w_grant_data && mem_wena) ? mem_wdata : '0;
        r_req_wstrb <= (w_grant_data && mem_wena) ? mask_to_strb(mem_wmask) : '0;
      end

      // Stores never touch mem_rdata; timed-out reads return zero.
      if (r_state == ARB_WAIT) begin
        if (bus_resp_valid) begin
          if (r_owner == ARB_OWN_INST)  r_inst_rdata <= bus_resp_rdata;
          else if (!r_req_wen)          r_mem_rdata  <= bus_resp_rdata;
        end else if (w_expired) begin
          r_bus_err <= 1'b1;
          if (r_owner == ARB_OWN_INST)  r_inst_rdata <= '0;
          else if (!r_req_wen)          r_mem_rdata  <= '0;
        end
      end

      if (r_state == ARB_DONE) begin
        r_last_owner <= r_owner;
      end
    end
  end

  assign inst_rdata    = r_inst_rdata;
  assign inst_ready    = r_inst_ready;
  assign mem_rdata     = r_mem_rdata;
  assign mem_ready     = r_mem_ready;
  assign bus_req_valid = r_req_valid;
  assign bus_req_addr  = r_req_addr;
  assign bus_req_wen   = r_req_wen;
  assign bus_req_wdata = r_req_wdata;
  assign bus_req_wstrb = r_req_wstrb;
  assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: fetch, store, backpressure, contention,
// watchdog timeout and reset during a wait.
module tb_core_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_ena;
  logic [63:0] inst_addr;
  logic [63:0] inst_rdata;
  logic        inst_ready;
  logic        mem_rena;
  logic [63:0] mem_raddr;
  logic        mem_wena;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_req_addr;
  logic        bus_req_wen;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_rdata;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  core_bus_arbiter #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_ena       (inst_ena),
    .inst_addr      (inst_addr),
    .inst_rdata     (inst_rdata),
    .inst_ready     (inst_ready),
    .mem_rena       (mem_rena),
    .mem_raddr      (mem_raddr),
    .mem_wena       (mem_wena),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_addr   (bus_req_addr),
    .bus_req_wen    (bus_req_wen),
    .bus_req_wdata  (bus_req_wdata),
    .bus_req_wstrb  (bus_req_wstrb),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_rdata (bus_resp_rdata),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},      {63'd0, bus_req_valid}, 64'd0);
    check({tag, "_inst_ready"}, {63'd0, inst_ready},    64'd0);
    check({tag, "_mem_ready"},  {63'd0, mem_ready},     64'd0);
    check({tag, "_inst_rdata"}, inst_rdata,             64'd0);
    check({tag, "_mem_rdata"},  mem_rdata,              64'd0);
    check({tag, "_addr"},       bus_req_addr,           64'd0);
    check({tag, "_wen"},        {63'd0, bus_req_wen},   64'd0);
    check({tag, "_wstrb"},      {56'd0, bus_req_wstrb}, 64'd0);
    check({tag, "_err"},        {63'd0, bus_err},       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  cyc;
    logic exp_data;

    rst = 1'b1;
    inst_ena = 1'b0;  inst_addr = '0;
    mem_rena = 1'b0;  mem_raddr = '0;
    mem_wena = 1'b0;  mem_waddr = '0;  mem_wdata = '0;  mem_wmask = '0;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;  bus_resp_rdata = '0;

    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;

    // Store: bytes 3 and 4 enabled, low address bits dropped.
    mem_wena = 1'b1;  mem_waddr = 64'h8000_0013;
    mem_wdata = 64'h0000_00AB_CD00_0000;  mem_wmask = 64'h0000_00FF_FF00_0000;
    bus_req_ready = 1'b1;
    step();
    check("st_valid", {63'd0, bus_req_valid}, 64'd1);
    check("st_wen",   {63'd0, bus_req_wen},   64'd1);
    check("st_addr",  bus_req_addr,           64'h8000_0010);
    check("st_wstrb", {56'd0, bus_req_wstrb}, 64'h18);
    check("st_wdata", bus_req_wdata,          64'h0000_00AB_CD00_0000);
    mem_wena = 1'b0;
    step();
    check("st_valid_drop", {63'd0, bus_req_valid}, 64'd0);
    bus_resp_valid = 1'b1;  bus_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    bus_resp_valid = 1'b0;
    check("st_mem_ready",  {63'd0, mem_ready},  64'd1);
    check("st_inst_ready", {63'd0, inst_ready}, 64'd0);
    check("st_mem_rdata",  mem_rdata,           64'd0);
    step();
    check("st_ready_pulse", {63'd0, mem_ready}, 64'd0);

    // Load with bus_req_ready low for 5 cycles.
    mem_rena = 1'b1;  mem_raddr = 64'h8000_0104;
    bus_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      mem_rena = 1'b0;
      check("bp_valid", {63'd0, bus_req_valid}, 64'd1);
      check("bp_addr",  bus_req_addr,           64'h8000_0100);
      check("bp_wen",   {63'd0, bus_req_wen},   64'd0);
    end
    step();
    check("bp_valid6", {63'd0, bus_req_valid}, 64'd1);
    check("bp_addr6",  bus_req_addr,           64'h8000_0100);
    bus_req_ready = 1'b1;
    step();
    check("bp_valid_drop", {63'd0, bus_req_valid}, 64'd0);
    check("bp_no_early",   {63'd0, mem_ready},     64'd0);
    bus_resp_valid = 1'b1;  bus_resp_rdata = 64'h5555_AAAA_0123_4567;
    step();
    bus_resp_valid = 1'b0;
    check("bp_mem_ready", {63'd0, mem_ready}, 64'd1);
    check("bp_mem_rdata", mem_rdata,          64'h5555_AAAA_0123_4567);
    step();

    // Single fetch, best-case latency.
    inst_ena = 1'b1;  inst_addr = 64'h8000_0004;
    step();
    check("if_valid", {63'd0, bus_req_valid}, 64'd1);
    check("if_addr",  bus_req_addr,           64'h8000_0000);
    check("if_wen",   {63'd0, bus_req_wen},   64'd0);
    inst_ena = 1'b0;
    step();
    bus_resp_valid = 1'b1;  bus_resp_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    bus_resp_valid = 1'b0;
    check("if_inst_ready", {63'd0, inst_ready}, 64'd1);
    check("if_mem_ready",  {63'd0, mem_ready},  64'd0);
    check("if_inst_rdata", inst_rdata,          64'h1234_5678_9ABC_DEF0);
    check("if_mem_keep",   mem_rdata,           64'h5555_AAAA_0123_4567);
    step();
    check("if_ready_pulse", {63'd0, inst_ready}, 64'd0);

    // Contention: both held high, grants alternate DATA, INST, DATA, INST.
    inst_ena = 1'b1;  inst_addr = 64'h8000_0044;
    mem_rena = 1'b1;  mem_raddr = 64'h8000_0204;
    for (int k = 0; k < 4; k++) begin
      exp_data = (k % 2 == 0);
      step();
      check("ct_valid", {63'd0, bus_req_valid}, 64'd1);
      check("ct_addr",  bus_req_addr, exp_data ? 64'h8000_0200 : 64'h8000_0040);
      step();
      bus_resp_valid = 1'b1;  bus_resp_rdata = 64'h1000 + 64'(k);
      step();
      bus_resp_valid = 1'b0;
      check("ct_mem_ready",  {63'd0, mem_ready},  {63'd0, exp_data});
      check("ct_inst_ready", {63'd0, inst_ready}, {63'd0, ~exp_data});
      check("ct_rdata", exp_data ? mem_rdata : inst_rdata, 64'h1000 + 64'(k));
      if (k == 3) begin
        inst_ena = 1'b0;
        mem_rena = 1'b0;
      end
      step();
    end
    check("ct_idle", {63'd0, bus_req_valid}, 64'd0);

    // Load with no response: watchdog ends it after 4 WAIT cycles.
    mem_rena = 1'b1;  mem_raddr = 64'h8000_0300;
    step();
    mem_rena = 1'b0;
    check("to_valid", {63'd0, bus_req_valid}, 64'd1);
    cyc = 1;
    while (!mem_ready && cyc < 20) begin
      step();
      cyc++;
    end
    check("to_latency",   64'(cyc),          64'd6);
    check("to_mem_ready", {63'd0, mem_ready}, 64'd1);
    check("to_mem_rdata", mem_rdata,          64'd0);
    check("to_err",       {63'd0, bus_err},   64'd1);
    step();
    bus_resp_valid = 1'b1;  bus_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus_resp_valid = 1'b0;
    check("late_mem_ready",  {63'd0, mem_ready},     64'd0);
    check("late_inst_ready", {63'd0, inst_ready},    64'd0);
    check("late_valid",      {63'd0, bus_req_valid}, 64'd0);
    check("late_rdata",      mem_rdata,              64'd0);
    check("late_err",        {63'd0, bus_err},       64'd1);

    // Reset asserted for one cycle while a fetch waits for its response.
    inst_ena = 1'b1;  inst_addr = 64'h8000_0008;
    step();
    inst_ena = 1'b0;
    check("rw_valid", {63'd0, bus_req_valid}, 64'd1);
    step();
    rst = 1'b1;
    step();
    check_idle_outputs("rw_reset");
    rst = 1'b0;
    bus_resp_valid = 1'b1;  bus_resp_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    bus_resp_valid = 1'b0;
    check("rw_stale_inst", {63'd0, inst_ready}, 64'd0);
    check("rw_stale_mem",  {63'd0, mem_ready},  64'd0);
    check("rw_stale_data", inst_rdata,          64'd0);

    // Fresh fetch after reset proves the FSM restarted from IDLE.
    inst_ena = 1'b1;  inst_addr = 64'h8000_0018;
    step();
    inst_ena = 1'b0;
    check("rf_valid", {63'd0, bus_req_valid}, 64'd1);
    check("rf_addr",  bus_req_addr,           64'h8000_0018);
    step();
    bus_resp_valid = 1'b1;  bus_resp_rdata = 64'hCAFE_F00D_0000_0001;
    step();
    bus_resp_valid = 1'b0;
    check("rf_inst_ready", {63'd0, inst_ready}, 64'd1);
    check("rf_inst_rdata", inst_rdata,          64'hCAFE_F00D_0000_0001);
    check("rf_err",        {63'd0, bus_err},    64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
